// File: rtl/accel_core_pkg.sv
// Shared definitions for the accelerator core: config field layout,
// accumulator FSM states and a saturation helper.
package accel_core_pkg;

  localparam int NPIX_LSB  = 0;
  localparam int NPIX_W    = 16;
  localparam int NPASS_LSB = 16;
  localparam int NPASS_W   = 8;
  localparam int SHIFT_LSB = 24;
  localparam int SHIFT_W   = 4;
  localparam int RELU_BIT  = 28;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // Clamp a sign-extended value to a signed ow-bit range (ow <= 32).
  function automatic logic signed [31:0] sat_to(
    input logic signed [63:0] v,
    input int                 ow
  );
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    logic signed [63:0] r;
    mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (ow - 1));
    if (v > mx) r = mx;
    else if (v < mn) r = mn;
    else r = v;
    return r[31:0];
  endfunction

endpackage

// File: rtl/psum_line_buffer.sv
// Line buffer of per-pixel running sums: comb read, registered write.
// Ports: rd_addr/rd_data read port; wr_en/wr_addr/wr_data write port.
module psum_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 80,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Writes land in a pending stage and commit one cycle later, so the
  // array write port is off the accumulate path. The pending entry is
  // forwarded to the read port, which covers npix==1 back-to-back.
  logic             pend_v_q, pend_v_d;
  logic [AW-1:0]    pend_a_q, pend_a_d;
  logic [WIDTH-1:0] pend_w_q, pend_w_d;

  always_comb begin
    pend_v_d = wr_en;
    pend_a_d = wr_addr;
    pend_w_d = wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      pend_w_q <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      pend_w_q <= pend_w_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_v_q) mem_q[pend_a_q] <= pend_w_q;
  end

  always_comb begin
    if (pend_v_q && pend_a_q == rd_addr) rd_data = pend_w_q;
    else rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/line_psum_accumulator.sv
// Multi-pass psum accumulator over a line of pixels with shift/ReLU/sat.
// Ports: i_psum/i_psum_val in, i_conf_* job control, o_psum/o_* status.
module line_psum_accumulator
  import accel_core_pkg::*;
#(
  parameter int NUM_KERNEL = 4,
  parameter int PSUM_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int DEPTH      = 64,
  parameter int REG_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_KERNEL*PSUM_WIDTH-1:0] i_psum,
  input  logic                             i_psum_val,
  input  logic [REG_WIDTH-1:0]             i_conf_ctrl,
  input  logic                             i_conf_start,
  output logic [NUM_KERNEL*OUT_WIDTH-1:0]  o_psum,
  output logic                             o_psum_val,
  output logic                             o_done,
  output logic                             o_busy,
  output logic                             o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = NUM_KERNEL * ACC_WIDTH;
  localparam int OW = NUM_KERNEL * OUT_WIDTH;
  localparam logic [15:0] DEPTH_L = 16'(DEPTH);

  acc_state_e state_q, state_d;
  logic [15:0] pix_q, pix_d, npix_q, npix_d;
  logic [7:0]  pass_q, pass_d, npass_q, npass_d;
  logic [3:0]  shift_q, shift_d;
  logic        relu_q, relu_d;
  logic        err_q, err_d;
  logic [OW-1:0] out_q, out_d;
  logic        val_q, val_d;
  logic        done_q, done_d;

  logic [NPIX_W-1:0]  c_npix;
  logic [NPASS_W-1:0] c_npass;
  logic [SHIFT_W-1:0] c_shift;
  logic               c_relu;
  logic               c_ok;
  logic               unused_cfg;

  assign c_npix  = i_conf_ctrl[NPIX_LSB +: NPIX_W];
  assign c_npass = i_conf_ctrl[NPASS_LSB +: NPASS_W];
  assign c_shift = i_conf_ctrl[SHIFT_LSB +: SHIFT_W];
  assign c_relu  = i_conf_ctrl[RELU_BIT];
  assign unused_cfg = ^i_conf_ctrl[REG_WIDTH-1:RELU_BIT+1];
  assign c_ok = (c_npix != '0) && (c_npix <= DEPTH_L) && (c_npass != '0);

  logic [BW-1:0] rd_data, wr_data;
  logic          wr_en;
  logic [OW-1:0] out_vec;

  psum_line_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (BW),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (pix_q[AW-1:0]),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (pix_q[AW-1:0]),
    .wr_data (wr_data)
  );

  always_comb begin : datapath
    logic signed [ACC_WIDTH-1:0] ps;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] sh;
    wr_data = '0;
    out_vec = '0;
    for (int k = 0; k < NUM_KERNEL; k++) begin
      ps  = ACC_WIDTH'(signed'(i_psum[k*PSUM_WIDTH +: PSUM_WIDTH]));
      if (pass_q == 8'd0) sum = ps;
      else sum = signed'(rd_data[k*ACC_WIDTH +: ACC_WIDTH]) + ps;
      wr_data[k*ACC_WIDTH +: ACC_WIDTH] = sum;
      sh = sum >>> shift_q;
      if (relu_q && sh < 0) sh = '0;
      out_vec[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sat_to(64'(sh), OUT_WIDTH));
    end
  end

  logic is_final, last_pix;
  assign is_final = (pass_q == npass_q - 8'd1);
  assign last_pix = (pix_q == npix_q - 16'd1);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    pass_d  = pass_q;
    npix_d  = npix_q;
    npass_d = npass_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    err_d   = err_q;
    out_d   = out_q;
    val_d   = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    if (i_conf_start) begin
      pix_d  = '0;
      pass_d = '0;
      if (c_ok) begin
        state_d = ACCUM;
        npix_d  = c_npix;
        npass_d = c_npass;
        shift_d = c_shift;
        relu_d  = c_relu;
        err_d   = 1'b0;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (i_psum_val) err_d = 1'b1;
      end
      ACCUM: begin
        if (!i_conf_start && i_psum_val) begin
          if (is_final) begin
            val_d = 1'b1;
            out_d = out_vec;
          end else begin
            wr_en = 1'b1;
          end
          if (last_pix) begin
            pix_d = '0;
            if (is_final) begin
              done_d  = 1'b1;
              state_d = IDLE;
              pass_d  = '0;
            end else begin
              pass_d = pass_q + 8'd1;
            end
          end else begin
            pix_d = pix_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pix_q   <= '0;
      pass_q  <= '0;
      npix_q  <= '0;
      npass_q <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      pass_q  <= pass_d;
      npix_q  <= npix_d;
      npass_q <= npass_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      err_q   <= err_d;
      out_q   <= out_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  assign o_psum     = out_q;
  assign o_psum_val = val_q;
  assign o_done     = done_q;
  assign o_busy     = (state_q == ACCUM);
  assign o_err      = err_q;

endmodule

// File: tb/tb_line_psum_accumulator.sv
// Directed self-checking bench for line_psum_accumulator.
// Inputs change 1ns after posedge; outputs checked 1ns after posedge.
module tb_line_psum_accumulator;

  logic        clk;
  logic        rst;
  logic [31:0] i_psum;
  logic        i_psum_val;
  logic [31:0] i_conf_ctrl;
  logic        i_conf_start;
  logic [31:0] o_psum;
  logic        o_psum_val;
  logic        o_done;
  logic        o_busy;
  logic        o_err;

  int total;
  int passed;

  line_psum_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .i_psum       (i_psum),
    .i_psum_val   (i_psum_val),
    .i_conf_ctrl  (i_conf_ctrl),
    .i_conf_start (i_conf_start),
    .o_psum       (o_psum),
    .o_psum_val   (o_psum_val),
    .o_done       (o_done),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(int npix, int npass, int sh, bit relu);
    return {3'b0, relu, 4'(sh), 8'(npass), 16'(npix)};
  endfunction

  function automatic logic [31:0] pk(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int kout(int k);
    logic signed [7:0] v;
    v = o_psum[k*8 +: 8];
    return int'(v);
  endfunction

  task automatic start(input logic [31:0] cfg);
    i_conf_ctrl  = cfg;
    i_conf_start = 1'b1;
    @(posedge clk); #1;
    i_conf_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    i_psum     = v;
    i_psum_val = 1'b1;
    @(posedge clk); #1;
    i_psum_val = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    i_psum = '0; i_psum_val = 1'b0;
    i_conf_ctrl = '0; i_conf_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_psum !== 32'd0) $display("FAIL rst_psum got=%0h exp=0", o_psum); else passed++;
    total++; if (o_psum_val !== 1'b0) $display("FAIL rst_val got=%0b exp=0", o_psum_val); else passed++;
    total++; if (o_done !== 1'b0) $display("FAIL rst_done got=%0b exp=0", o_done); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", o_busy); else passed++;
    total++; if (o_err !== 1'b0) $display("FAIL rst_err got=%0b exp=0", o_err); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_npix1(input bit relu);
    start(mk(1, 3, 0, relu));
    total++; if (o_busy !== 1'b1) $display("FAIL n1_busy got=%0b exp=1", o_busy); else passed++;
    send(pk(10, 100, -100, 0));
    total++; if (o_psum_val !== 1'b0) $display("FAIL n1_val0 got=%0b exp=0", o_psum_val); else passed++;
    send(pk(20, 100, -100, 0));
    total++; if (o_psum_val !== 1'b0) $display("FAIL n1_val1 got=%0b exp=0", o_psum_val); else passed++;
    send(pk(30, 100, -100, 0));
    total++; if (o_psum_val !== 1'b1) $display("FAIL n1_val2 got=%0b exp=1", o_psum_val); else passed++;
    total++; if (o_done !== 1'b1) $display("FAIL n1_done got=%0b exp=1", o_done); else passed++;
    total++; if (kout(0) !== 60) $display("FAIL n1_k0 got=%0d exp=60", kout(0)); else passed++;
    total++; if (kout(1) !== 127) $display("FAIL n1_k1 got=%0d exp=127", kout(1)); else passed++;
    if (relu) begin
      total++; if (kout(2) !== 0) $display("FAIL n1_k2relu got=%0d exp=0", kout(2)); else passed++;
    end else begin
      total++; if (kout(2) !== -128) $display("FAIL n1_k2 got=%0d exp=-128", kout(2)); else passed++;
    end
    total++; if (o_busy !== 1'b0) $display("FAIL n1_busy_end got=%0b exp=0", o_busy); else passed++;
    @(posedge clk); #1;
    total++; if (o_psum_val !== 1'b0) $display("FAIL n1_val_after got=%0b exp=0", o_psum_val); else passed++;
  endtask

  task automatic test_line;
    start(mk(4, 2, 0, 0));
    for (int p = 0; p < 4; p++) begin
      send(pk(p + 1, -(p + 1), 0, 0));
      total++; if (o_psum_val !== 1'b0) $display("FAIL line_p0_val%0d got=%0b exp=0", p, o_psum_val); else passed++;
    end
    for (int p = 0; p < 4; p++) begin
      send(pk(10, 10, 0, 0));
      total++; if (o_psum_val !== 1'b1) $display("FAIL line_val%0d got=%0b exp=1", p, o_psum_val); else passed++;
      total++; if (kout(0) !== 11 + p) $display("FAIL line_k0_%0d got=%0d exp=%0d", p, kout(0), 11 + p); else passed++;
      total++; if (kout(1) !== 9 - p) $display("FAIL line_k1_%0d got=%0d exp=%0d", p, kout(1), 9 - p); else passed++;
      total++; if (o_done !== (p == 3)) $display("FAIL line_done%0d got=%0b exp=%0b", p, o_done, p == 3); else passed++;
    end
  endtask

  task automatic test_shift;
    start(mk(2, 1, 2, 0));
    send(pk(61, -61, 0, 0));
    total++; if (kout(0) !== 15) $display("FAIL sh_a0 got=%0d exp=15", kout(0)); else passed++;
    total++; if (kout(1) !== -16) $display("FAIL sh_a1 got=%0d exp=-16", kout(1)); else passed++;
    total++; if (o_done !== 1'b0) $display("FAIL sh_done0 got=%0b exp=0", o_done); else passed++;
    send(pk(-61, 61, 0, 0));
    total++; if (kout(0) !== -16) $display("FAIL sh_b0 got=%0d exp=-16", kout(0)); else passed++;
    total++; if (kout(1) !== 15) $display("FAIL sh_b1 got=%0d exp=15", kout(1)); else passed++;
    total++; if (o_done !== 1'b1) $display("FAIL sh_done1 got=%0b exp=1", o_done); else passed++;
  endtask

  task automatic test_abort;
    start(mk(4, 3, 0, 0));
    send(pk(50, 50, 0, 0));
    send(pk(50, 50, 0, 0));
    start(mk(2, 2, 0, 0));
    total++; if (o_busy !== 1'b1) $display("FAIL ab_busy got=%0b exp=1", o_busy); else passed++;
    total++; if (o_done !== 1'b0) $display("FAIL ab_done got=%0b exp=0", o_done); else passed++;
    send(pk(5, -5, 0, 0));
    send(pk(6, -6, 0, 0));
    total++; if (o_psum_val !== 1'b0) $display("FAIL ab_p0val got=%0b exp=0", o_psum_val); else passed++;
    send(pk(1, 1, 0, 0));
    total++; if (kout(0) !== 6) $display("FAIL ab_k0a got=%0d exp=6", kout(0)); else passed++;
    total++; if (kout(1) !== -4) $display("FAIL ab_k1a got=%0d exp=-4", kout(1)); else passed++;
    total++; if (o_done !== 1'b0) $display("FAIL ab_donea got=%0b exp=0", o_done); else passed++;
    send(pk(2, 2, 0, 0));
    total++; if (kout(0) !== 8) $display("FAIL ab_k0b got=%0d exp=8", kout(0)); else passed++;
    total++; if (o_done !== 1'b1) $display("FAIL ab_doneb got=%0b exp=1", o_done); else passed++;
  endtask

  task automatic test_reset_mid;
    start(mk(2, 2, 0, 0));
    send(pk(3, 3, 3, 3));
    rst = 1'b0;
    #1;
    total++; if (o_psum !== 32'd0) $display("FAIL rm_psum got=%0h exp=0", o_psum); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL rm_busy got=%0b exp=0", o_busy); else passed++;
    total++; if (o_psum_val !== 1'b0) $display("FAIL rm_val got=%0b exp=0", o_psum_val); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (o_busy !== 1'b0) $display("FAIL rm_busy2 got=%0b exp=0", o_busy); else passed++;
  endtask

  task automatic test_err;
    start(mk(0, 1, 0, 0));
    total++; if (o_err !== 1'b1) $display("FAIL err_npix0 got=%0b exp=1", o_err); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL err_npix0_busy got=%0b exp=0", o_busy); else passed++;
    start(mk(1, 1, 0, 0));
    total++; if (o_err !== 1'b0) $display("FAIL err_clr1 got=%0b exp=0", o_err); else passed++;
    total++; if (o_busy !== 1'b1) $display("FAIL err_clr1_busy got=%0b exp=1", o_busy); else passed++;
    start(mk(65, 1, 0, 0));
    total++; if (o_err !== 1'b1) $display("FAIL err_npix65 got=%0b exp=1", o_err); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL err_npix65_busy got=%0b exp=0", o_busy); else passed++;
    start(mk(64, 1, 0, 0));
    total++; if (o_busy !== 1'b1) $display("FAIL err_npix64_busy got=%0b exp=1", o_busy); else passed++;
    start(mk(4, 0, 0, 0));
    total++; if (o_err !== 1'b1) $display("FAIL err_npass0 got=%0b exp=1", o_err); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL err_npass0_busy got=%0b exp=0", o_busy); else passed++;
    start(mk(1, 1, 0, 0));
    total++; if (o_err !== 1'b0) $display("FAIL err_clr2 got=%0b exp=0", o_err); else passed++;
    send(pk(7, 0, 0, 0));
    total++; if (kout(0) !== 7) $display("FAIL err_pass1 got=%0d exp=7", kout(0)); else passed++;
    send(pk(9, 0, 0, 0));
    total++; if (o_err !== 1'b1) $display("FAIL err_idleval got=%0b exp=1", o_err); else passed++;
    total++; if (o_psum_val !== 1'b0) $display("FAIL err_idleval_out got=%0b exp=0", o_psum_val); else passed++;
    start(mk(1, 1, 0, 0));
    total++; if (o_err !== 1'b0) $display("FAIL err_clr3 got=%0b exp=0", o_err); else passed++;
    send(pk(-4, 0, 0, 0));
    total++; if (kout(0) !== -4) $display("FAIL err_final got=%0d exp=-4", kout(0)); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_npix1(1'b0);
    test_npix1(1'b1);
    test_line();
    test_shift();
    test_abort();
    test_reset_mid();
    test_err();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
